adc_responder: RTL and testbench

ADC_RESPONDER -- requirements
Module: adc_responder

---
 rtl/adc_responder.sv | 168 ++++++++++++++++
 tb/tb_adc_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// Serial ADC responder: answers an SPI-style initiator with a 16-bit frame
// {2'b00, sample, 2'b00} and generates test patterns frame by frame.
module adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int SQUARE_HALF = 64
) (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic        adc_clk,
    input  logic        adc_conv,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  step,
    input  logic [11:0] const_value,
    output logic        adc_data,
    output logic [11:0] sample_value,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [15:0] SQ_LAST = 16'(SQUARE_HALF - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] conv_sync;
    logic        clk_prev;
    logic        conv_prev;
    logic [1:0]  state;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic        dir_up;
    logic [15:0] sq_cnt;

    logic        clk_s;
    logic        conv_s;
    logic        clk_fall;
    logic        conv_fall;
    logic        conv_rise;
    logic [12:0] up_sum;
    logic [12:0] down_diff;
    logic [11:0] next_sample;
    logic        next_dir;
    logic [15:0] next_sq;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign conv_s    = conv_sync[SYNC_STAGES-1];
    assign clk_fall  = clk_prev & ~clk_s;
    assign conv_fall = conv_prev & ~conv_s;
    assign conv_rise = ~conv_prev & conv_s;
    assign busy      = (state == SHIFT);

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '0;
            conv_sync <= '0;
        end else begin
            clk_sync[0]  <= adc_clk;
            conv_sync[0] <= adc_conv;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                conv_sync[i] <= conv_sync[i-1];
            end
        end
    end

    // Triangle math is done in 13 bits so the clamps at 0 and 4095 never wrap.
    assign up_sum    = {1'b0, sample_value} + {5'b0, step};
    assign down_diff = {1'b0, sample_value} - {5'b0, step};

    always_comb begin
        next_sample = sample_value;
        next_dir    = dir_up;
        next_sq     = sq_cnt;
        case (mode)
            2'b00: next_sample = sample_value + {4'b0, step};
            2'b01: begin
                if (dir_up) begin
                    if (up_sum >= 13'd4095) begin
                        next_sample = 12'hFFF;
                        next_dir    = 1'b0;
                    end else begin
                        next_sample = up_sum[11:0];
                    end
                end else begin
                    if (down_diff[12] || (down_diff == 13'd0)) begin
                        next_sample = 12'h000;
                        next_dir    = 1'b1;
                    end else begin
                        next_sample = down_diff[11:0];
                    end
                end
            end
            2'b10: next_sample = const_value;
            2'b11: begin
                if (sq_cnt == SQ_LAST) begin
                    next_sq     = 16'd0;
                    next_sample = (sample_value == 12'h000) ? 12'hFFF : 12'h000;
                end else begin
                    next_sq = sq_cnt + 16'd1;
                end
            end
        endcase
    end

    // Bit 0 of the frame is always zero, so leaving SHIFT with adc_data=0
    // still presents the 16th bit correctly.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            clk_prev     <= 1'b0;
            conv_prev    <= 1'b0;
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            adc_data     <= 1'b0;
            sample_value <= '0;
            frame_count  <= '0;
            dir_up       <= 1'b1;
            sq_cnt       <= '0;
        end else begin
            clk_prev  <= clk_s;
            conv_prev <= conv_s;
            if (!enable) begin
                state    <= IDLE;
                adc_data <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        adc_data <= 1'b0;
                        if (conv_s) state <= ARMED;
                    end
                    ARMED: begin
                        adc_data <= 1'b0;
                        if (conv_fall) begin
                            shreg   <= {2'b00, sample_value, 2'b00};
                            bit_cnt <= 5'd0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (conv_rise) begin
                            adc_data <= 1'b0;
                            state    <= ARMED;
                        end else if (clk_fall) begin
                            adc_data <= shreg[15];
                            shreg    <= {shreg[14:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) state <= DONE;
                        end
                    end
                    DONE: begin
                        adc_data     <= 1'b0;
                        frame_count  <= frame_count + 16'd1;
                        sample_value <= next_sample;
                        dir_up       <= next_dir;
                        sq_cnt       <= next_sq;
                        state        <= ARMED;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: plays the ADC initiator and compares
// received serial words and status outputs against hand-computed values.
module tb_adc_responder;

    logic        osc_clk = 1'b0;
    logic        reset;
    logic        adc_clk;
    logic        adc_conv;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  step;
    logic [11:0] const_value;
    logic        adc_data;
    logic [11:0] sample_value;
    logic [15:0] frame_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    adc_responder #(.SYNC_STAGES(2), .SQUARE_HALF(4)) dut (
        .osc_clk      (osc_clk),
        .reset        (reset),
        .adc_clk      (adc_clk),
        .adc_conv     (adc_conv),
        .enable       (enable),
        .mode         (mode),
        .step         (step),
        .const_value  (const_value),
        .adc_data     (adc_data),
        .sample_value (sample_value),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] s, input logic [11:0] c);
        mode        = m;
        step        = s;
        const_value = c;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    // Initiator: conv high, conv low, then nbits adc_clk periods sampling on the rising edge.
    task automatic startFrame(input int nbits, output logic [15:0] word);
        word     = '0;
        adc_conv = 1'b1;
        adc_clk  = 1'b1;
        waitCycles(8);
        adc_conv = 1'b0;
        waitCycles(8);
        for (int k = 0; k < nbits; k++) begin
            adc_clk = 1'b0;
            waitCycles(4);
            word    = {word[14:0], adc_data};
            adc_clk = 1'b1;
            waitCycles(4);
        end
    endtask

    task automatic endFrame();
        adc_conv = 1'b1;
        waitCycles(8);
    endtask

    task automatic runFrame(input string tag, input logic [15:0] expected);
        logic [15:0] w;
        startFrame(16, w);
        endFrame();
        checkOutput(tag, w, expected);
    endtask

    task automatic doReset();
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(4);
    endtask

    initial begin
        logic [15:0] w;
        reset    = 1'b1;
        adc_clk  = 1'b1;
        adc_conv = 1'b1;
        enable   = 1'b1;
        applyStimulus(2'b00, 8'h00, 12'h000);
        waitCycles(2);
        checkOutput("reset adc_data", {15'b0, adc_data}, 16'h0000);
        checkOutput("reset busy", {15'b0, busy}, 16'h0000);
        checkOutput("reset sample", {4'b0, sample_value}, 16'h0000);
        checkOutput("reset count", frame_count, 16'h0000);
        reset = 1'b0;
        waitCycles(4);

        // Ramp
        applyStimulus(2'b00, 8'h10, 12'h000);
        runFrame("ramp f1", 16'h0000);
        runFrame("ramp f2", 16'h0040);
        runFrame("ramp f3", 16'h0080);
        checkOutput("ramp count", frame_count, 16'd3);
        checkOutput("ramp sample", {4'b0, sample_value}, 16'h0030);

        // Abort after 7 bits
        startFrame(7, w);
        checkOutput("abort busy mid", {15'b0, busy}, 16'h0001);
        endFrame();
        checkOutput("abort adc_data", {15'b0, adc_data}, 16'h0000);
        checkOutput("abort busy", {15'b0, busy}, 16'h0000);
        checkOutput("abort count", frame_count, 16'd3);
        checkOutput("abort sample", {4'b0, sample_value}, 16'h0030);
        runFrame("after abort", 16'h00C0);
        checkOutput("after abort count", frame_count, 16'd4);

        // adc_clk toggling while conv high is ignored
        for (int i = 0; i < 4; i++) begin
            adc_clk = 1'b0;
            waitCycles(4);
            adc_clk = 1'b1;
            waitCycles(4);
        end
        checkOutput("idle clk busy", {15'b0, busy}, 16'h0000);
        checkOutput("idle clk count", frame_count, 16'd4);
        runFrame("after idle clk", 16'h0100);

        // Enable dropped mid-frame
        startFrame(5, w);
        enable = 1'b0;
        waitCycles(3);
        checkOutput("disable busy", {15'b0, busy}, 16'h0000);
        checkOutput("disable adc_data", {15'b0, adc_data}, 16'h0000);
        enable = 1'b1;
        endFrame();
        checkOutput("disable count", frame_count, 16'd5);
        checkOutput("disable sample", {4'b0, sample_value}, 16'h0050);
        runFrame("after disable", 16'h0140);

        // step = 0 holds the sample
        applyStimulus(2'b00, 8'h00, 12'h000);
        runFrame("step0 f1", 16'h0180);
        runFrame("step0 f2", 16'h0180);
        checkOutput("step0 sample", {4'b0, sample_value}, 16'h0060);
        checkOutput("step0 count", frame_count, 16'd8);

        // Constant, with a const_value change while the second frame is in flight
        doReset();
        applyStimulus(2'b10, 8'h00, 12'hABC);
        runFrame("const f1", 16'h0000);
        fork
            startFrame(16, w);
            begin
                waitCycles(60);
                const_value = 12'h123;
            end
        join
        endFrame();
        checkOutput("const f2", w, 16'h2AF0);
        checkOutput("const resample", {4'b0, sample_value}, 16'h0123);
        runFrame("const f3", 16'h048C);

        // Triangle from 0xF00 with step 0xFF, then the lower clamp
        doReset();
        applyStimulus(2'b10, 8'h00, 12'hF00);
        runFrame("tri seed", 16'h0000);
        applyStimulus(2'b01, 8'hFF, 12'h000);
        runFrame("tri f1", 16'h3C00);
        runFrame("tri f2", 16'h3FFC);
        runFrame("tri f3", 16'h3C00);
        checkOutput("tri down", {4'b0, sample_value}, 16'h0E01);
        applyStimulus(2'b10, 8'hFF, 12'h050);
        runFrame("tri f4", 16'h3804);
        applyStimulus(2'b01, 8'hFF, 12'h000);
        runFrame("tri f5", 16'h0140);
        runFrame("tri floor", 16'h0000);
        checkOutput("tri up again", {4'b0, sample_value}, 16'h00FF);

        // Square with a half period of 4 frames
        doReset();
        applyStimulus(2'b11, 8'h00, 12'h000);
        for (int i = 1; i <= 9; i++) begin
            runFrame($sformatf("square f%0d", i), (i >= 5 && i <= 8) ? 16'h3FFC : 16'h0000);
        end
        checkOutput("square count", frame_count, 16'd9);

        // Reset during bit 10 of a frame
        doReset();
        applyStimulus(2'b00, 8'h08, 12'h000);
        runFrame("rst f1", 16'h0000);
        runFrame("rst f2", 16'h0020);
        startFrame(9, w);
        adc_clk = 1'b0;
        waitCycles(4);
        checkOutput("pre-reset adc_data", {15'b0, adc_data}, 16'h0001);
        checkOutput("pre-reset busy", {15'b0, busy}, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid reset adc_data", {15'b0, adc_data}, 16'h0000);
        checkOutput("mid reset busy", {15'b0, busy}, 16'h0000);
        checkOutput("mid reset sample", {4'b0, sample_value}, 16'h0000);
        checkOutput("mid reset count", frame_count, 16'h0000);
        @(negedge osc_clk);
        waitCycles(2);
        reset    = 1'b0;
        adc_clk  = 1'b1;
        adc_conv = 1'b1;
        waitCycles(4);
        runFrame("post reset frame", 16'h0000);
        checkOutput("post reset count", frame_count, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
